vga_timing_gen_param: RTL

//  Parametrised VGA sync/timing generator running on the 100 MHz system clock with an internal pixel-enable divider.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_timing_gen_param_clk_en_divider.sv | 44 ++++
 rtl/vga_timing_gen_param.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA timing generator.
// Holds the 640x480@60 defaults, frame totals, sync window bounds, and a
// counter-width helper that never returns zero.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Sync is asserted on [sync_start, sync_end).
  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_end(input int act, input int fp, input int sync);
    return act + fp + sync;
  endfunction

  // A counter that counts to n-1 needs $clog2(n) bits, but at least one.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen_param_clk_en_divider.sv
// clk_en_divider: produces a one-clk enable pulse every DIV system clocks.
// Ports:
//   clk        system clock
//   CPU_RESETN asynchronous active-low reset
//   enable     1 = count; 0 = hold the divider phase
//   tick       high during the clk in which the divider sits at DIV-1
module clk_en_divider
  import vga_timing_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic CPU_RESETN,
  input  logic enable,
  output logic tick
);

  localparam int            DW       = cnt_w(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          at_last;

  always_comb begin
    at_last = (div_q == DIV_LAST);
    div_d   = div_q;
    if (enable) begin
      div_d = at_last ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Gating with the reset keeps the DIV=1 case (tick = enable) quiet in reset.
  assign tick = enable && at_last && CPU_RESETN;

endmodule

// File: rtl/vga_timing_gen_param.sv
// vga_timing_gen_param: parametrised VGA sync/timing generator on the system
// clock, with an internal pixel-enable divider.
// Ports:
//   clk          system clock
//   CPU_RESETN   asynchronous active-low reset
//   enable       1 = run; 0 = freeze counters and registered outputs
//   pix_en       one-clk pulse per pixel slot
//   hSync/vSync  sync outputs, asserted level HS_POL / VS_POL
//   active       (x,y) inside the visible region
//   x, y         visible column / row, 0 outside the visible region
//   line_start   one-clk pulse when the column counter wraps to 0
//   screenEnd    one-clk pulse when (h,v) wraps to (0,0)
//   frame_count  number of screenEnd pulses since reset, wrapping
module vga_timing_gen_param
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   X_W      = 10,
  parameter int   Y_W      = 9,
  parameter int   FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               CPU_RESETN,
  input  logic               enable,
  output logic               pix_en,
  output logic               hSync,
  output logic               vSync,
  output logic               active,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               line_start,
  output logic               screenEnd,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL  = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HC_W     = cnt_w(H_TOTAL);
  localparam int VC_W     = cnt_w(V_TOTAL);
  localparam int HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

  // Half-open window test done in 32 bits so a window ending exactly at
  // the total cannot overflow the counter width.
  function automatic logic in_window(input logic [31:0] v, input int lo, input int hi);
    return (v >= 32'(lo)) && (v < 32'(hi));
  endfunction

  logic [HC_W-1:0]    hc_q, hc_d;
  logic [VC_W-1:0]    vc_q, vc_d;
  logic [31:0]        hc_ext, vc_ext;
  logic               vis_n;
  logic               active_q, active_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               line_start_q, line_start_d;
  logic               screen_end_q, screen_end_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  clk_en_divider #(
    .DIV(CLK_DIV)
  ) u_div (
    .clk       (clk),
    .CPU_RESETN(CPU_RESETN),
    .enable    (enable),
    .tick      (pix_en)
  );

  // Stage: next raster position
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + VC_W'(1);
      end else begin
        hc_d = hc_q + HC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      hc_q <= H_LAST;
      vc_q <= V_LAST;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Stage: decode from the next position so outputs move with the counters
  always_comb begin
    hc_ext        = 32'(hc_d);
    vc_ext        = 32'(vc_d);
    vis_n         = (hc_ext < 32'(H_ACTIVE)) && (vc_ext < 32'(V_ACTIVE));
    active_d      = active_q;
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    screen_end_d  = 1'b0;
    frame_count_d = frame_count_q;
    if (pix_en) begin
      active_d     = vis_n;
      x_d          = vis_n ? X_W'(hc_d) : '0;
      y_d          = vis_n ? Y_W'(vc_d) : '0;
      hsync_d      = in_window(hc_ext, HS_START, HS_END) ? HS_POL : ~HS_POL;
      // vc_d only moves on an h wrap, so vSync can only change there.
      vsync_d      = in_window(vc_ext, VS_START, VS_END) ? VS_POL : ~VS_POL;
      line_start_d = (hc_d == '0);
      screen_end_d = (hc_d == '0) && (vc_d == '0);
      if (screen_end_d) begin
        frame_count_d = frame_count_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      screen_end_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      screen_end_q  <= screen_end_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign line_start  = line_start_q;
  assign screenEnd   = screen_end_q;
  assign frame_count = frame_count_q;

endmodule
